// File: rtl/kbd_spi_if.sv
// SPI-side read port of the keyboard scanner: address, one-cycle read strobe
// and registered read data returned the cycle after the strobe.
interface kbd_spi_if;
    logic [16:0] spi_addr_i;
    logic        spi_rd_en_i;
    logic [7:0]  spi_data_o;

    modport master (
        output spi_addr_i,
        output spi_rd_en_i,
        input  spi_data_o
    );

    modport slave (
        input  spi_addr_i,
        input  spi_rd_en_i,
        output spi_data_o
    );
endinterface

// File: rtl/kbd_scanner.sv
// PET keyboard matrix scanner: drives row select, samples active-low columns,
// debounces each row into a committed 16x8 image readable over SPI at $E800-$E810.
module kbd_scanner #(
    parameter int ROWS          = 10,
    parameter int SETTLE_CYCLES = 64,
    parameter int DEBOUNCE      = 3
) (
    input  logic        clk_bus_i,
    input  logic        reset_i,
    input  logic        scan_en_i,
    output logic [3:0]  kbd_row_o,
    input  logic [7:0]  kbd_col_i,
    kbd_spi_if.slave    spi,
    output logic        changed_o,
    output logic        scan_done_o
);

    localparam int            SW          = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    LAST_ROW    = 4'(ROWS - 1);
    localparam logic [1:0]    DEB_LIMIT   = 2'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        UPDATE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    kbd_row_q, kbd_row_d;
    logic [7:0]    sync1_q, sync2_q;
    logic [7:0]    s_q, s_d;
    logic          changed_q, changed_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic [7:0]    matrix_q [16];
    logic [7:0]    matrix_d [16];
    logic [7:0]    cand_q   [16];
    logic [7:0]    cand_d   [16];
    logic [1:0]    cnt_q    [16];
    logic [1:0]    cnt_d    [16];

    logic [15:0]   row_sel;
    logic [1:0]    ncnt;
    logic          commit;
    logic          is_matrix_addr;
    logic          is_status_addr;

    // ---------------- state register ----------------
    always_ff @(posedge clk_bus_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            row_q     <= 4'd0;
            settle_q  <= '0;
            kbd_row_q <= 4'hF;
            sync1_q   <= 8'hFF;
            sync2_q   <= 8'hFF;
            s_q       <= 8'hFF;
            changed_q <= 1'b0;
            rd_data_q <= 8'hFF;
            for (int i = 0; i < 16; i++) begin
                matrix_q[i] <= 8'hFF;
                cand_q[i]   <= 8'hFF;
                cnt_q[i]    <= 2'd0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            settle_q  <= settle_d;
            kbd_row_q <= kbd_row_d;
            sync1_q   <= kbd_col_i;
            sync2_q   <= sync1_q;
            s_q       <= s_d;
            changed_q <= changed_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < 16; i++) begin
                matrix_q[i] <= matrix_d[i];
                cand_q[i]   <= cand_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        s_d      = s_q;
        case (state_q)
            IDLE: begin
                row_d = 4'd0;
                if (scan_en_i) state_d = DRIVE;
            end
            DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == '0) state_d = SAMPLE;
                else                settle_d = settle_q - 1'b1;
            end
            SAMPLE: begin
                s_d     = sync2_q;
                state_d = UPDATE;
            end
            UPDATE: begin
                row_d   = (row_q == LAST_ROW) ? 4'd0 : 4'(row_q + 4'd1);
                state_d = scan_en_i ? DRIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
                row_d   = 4'd0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Row select is registered from the next state so the decoder sees clean
    // pin transitions: valid from the DRIVE cycle through UPDATE, F when idle.
    always_comb begin
        kbd_row_d   = (state_d == IDLE) ? 4'hF : row_d;
        scan_done_o = (state_q == UPDATE) && (row_q == LAST_ROW);
    end

    assign kbd_row_o = kbd_row_q;

    // ---------------- debounce datapath ----------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_row_sel
        if (gi < ROWS) begin : g_scanned
            assign row_sel[gi] = (state_q == UPDATE) && (row_q == 4'(gi));
        end else begin : g_unscanned
            assign row_sel[gi] = 1'b0;
        end
    end

    always_comb begin
        if (s_q == cand_q[row_q]) ncnt = (cnt_q[row_q] == 2'd3) ? 2'd3 : 2'(cnt_q[row_q] + 2'd1);
        else                      ncnt = 2'd1;
        commit = (state_q == UPDATE) && (ncnt >= DEB_LIMIT) && (s_q != matrix_q[row_q]);
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            matrix_d[i] = matrix_q[i];
            cand_d[i]   = cand_q[i];
            cnt_d[i]    = cnt_q[i];
            if (row_sel[i]) begin
                cand_d[i] = s_q;
                cnt_d[i]  = ncnt;
                if (commit) matrix_d[i] = s_q;
            end
        end
    end

    // ---------------- SPI read port ----------------
    // Reads use pre-edge state, so a coincident commit is seen on the next read.
    always_comb begin
        is_matrix_addr = (spi.spi_addr_i[16:4] == 13'hE80);
        is_status_addr = (spi.spi_addr_i == 17'hE810);
        rd_data_d      = rd_data_q;
        if (spi.spi_rd_en_i) begin
            if (is_matrix_addr)      rd_data_d = matrix_q[spi.spi_addr_i[3:0]];
            else if (is_status_addr) rd_data_d = {7'd0, changed_q};
            else                     rd_data_d = 8'hFF;
        end
        if (commit)                                   changed_d = 1'b1;
        else if (spi.spi_rd_en_i && is_status_addr)   changed_d = 1'b0;
        else                                          changed_d = changed_q;
    end

    assign spi.spi_data_o = rd_data_q;
    assign changed_o      = changed_q;

endmodule
